// File: rtl/lc3_pkg.sv
// Shared LC-3 decode definitions: opcodes, the link register index, immediate
// selection and the ID/EX payload layout.
package lc3_pkg;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_RES  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    localparam logic [2:0] REG_R7 = 3'd7;

    typedef enum logic [2:0] {
        ImmNone,
        ImmOff6,
        ImmOff9,
        ImmOff11,
        ImmTrap8
    } imm_sel_e;

    typedef struct packed {
        logic [3:0]  op;
        logic [2:0]  dr;
        logic        ld_reg;
        logic        setcc;
        logic [15:0] src1;
        logic [15:0] src2;
        logic [15:0] imm;
        logic [2:0]  nzp;
        logic [15:0] pc;
    } idex_t;

    // Builds the extended offset field chosen by the decoder.
    function automatic logic [15:0] imm_extend(input logic [15:0] instr, input imm_sel_e sel);
        logic [15:0] imm;
        case (sel)
            ImmOff6:  imm = {{10{instr[5]}}, instr[5:0]};
            ImmOff9:  imm = {{7{instr[8]}}, instr[8:0]};
            ImmOff11: imm = {{5{instr[10]}}, instr[10:0]};
            ImmTrap8: imm = {8'h00, instr[7:0]};
            default:  imm = 16'h0000;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/lc3_scoreboard.sv
// Per-register pending-write counters for RAW hazard detection.
// Counters go up on issue of a writer and down on writeback or on flush of a
// live writer; coincident events on one register net out.
module lc3_scoreboard
    import lc3_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc_i,
    input  logic [2:0] inc_idx_i,
    input  logic       wb_dec_i,
    input  logic [2:0] wb_idx_i,
    input  logic       fl_dec_i,
    input  logic [2:0] fl_idx_i,
    input  logic [2:0] src1_i,
    input  logic [2:0] src2_i,
    input  logic [2:0] dst_i,
    output logic       busy1_o,
    output logic       busy2_o,
    output logic       dst_full_o
);

    logic [1:0] cnt_q [8];
    logic [1:0] cnt_d [8];

    // Net the three possible events per register.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            cnt_d[i] = cnt_q[i]
                     + {1'b0, inc_i && (inc_idx_i == 3'(i))}
                     - {1'b0, wb_dec_i && (wb_idx_i == 3'(i))}
                     - {1'b0, fl_dec_i && (fl_idx_i == 3'(i))};
        end
    end

    // Counter state; reset clears all pending writes at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= 2'd0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // A single outstanding write retiring this cycle is bypassed through the
    // register file, so it does not count as busy.
    always_comb begin
        busy1_o    = (cnt_q[src1_i] != 2'd0) &&
                     !((cnt_q[src1_i] == 2'd1) && wb_dec_i && (wb_idx_i == src1_i));
        busy2_o    = (cnt_q[src2_i] != 2'd0) &&
                     !((cnt_q[src2_i] == 2'd1) && wb_dec_i && (wb_idx_i == src2_i));
        dst_full_o = (cnt_q[dst_i] == 2'd3);
    end

endmodule

// File: rtl/lc3_decode_stage.sv
// LC-3 decode / operand-fetch stage with ID/EX register and RAW scoreboard.
// Optional feature: define LC3_DECODE_ILLEGAL_EN to flag RTI and opcode 1101
// as illegal; otherwise they pass through as NOPs.
module lc3_decode_stage
    import lc3_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [15:0] if_instr,
    input  logic [15:0] if_pc,
    output logic [2:0]  SR1,
    output logic [2:0]  SR2,
    input  logic [15:0] SR1out,
    input  logic [15:0] SR2out,
    input  logic        wb_valid,
    input  logic [2:0]  wb_dr,
    input  logic        flush,
    input  logic        ex_ready,
    output logic        ex_valid,
    output logic [3:0]  ex_op,
    output logic [2:0]  ex_dr,
    output logic        ex_ld_reg,
    output logic        ex_setcc,
    output logic [15:0] ex_src1,
    output logic [15:0] ex_src2,
    output logic [15:0] ex_imm,
    output logic [2:0]  ex_nzp,
    output logic [15:0] ex_pc,
    output logic        ex_illegal
);

    logic [3:0] op;
    logic       use1, use2, ld_reg, setcc, illegal;
    logic [2:0] dr;
    imm_sel_e   imm_sel;
    logic       busy1, busy2, dst_full, hazard, issue;
    idex_t      dec, idex_d, idex_q;
    logic       ex_valid_d, ex_valid_q;

    assign op  = if_instr[15:12];
    assign SR1 = if_instr[8:6];
    assign SR2 = ((op == OP_ST) || (op == OP_STI) || (op == OP_STR)) ? if_instr[11:9]
                                                                     : if_instr[2:0];

    // Opcode decode into source-use, destination and immediate controls.
    always_comb begin
        use1    = 1'b0;
        use2    = 1'b0;
        ld_reg  = 1'b0;
        setcc   = 1'b0;
        dr      = 3'd0;
        imm_sel = ImmNone;
        illegal = 1'b0;
        case (op)
            OP_ADD, OP_AND: begin
                use1 = 1'b1; use2 = !if_instr[5];
                ld_reg = 1'b1; setcc = 1'b1; dr = if_instr[11:9];
            end
            OP_NOT: begin
                use1 = 1'b1; ld_reg = 1'b1; setcc = 1'b1; dr = if_instr[11:9];
            end
            OP_LD, OP_LDI, OP_LEA: begin
                ld_reg = 1'b1; setcc = 1'b1; dr = if_instr[11:9]; imm_sel = ImmOff9;
            end
            OP_LDR: begin
                use1 = 1'b1; ld_reg = 1'b1; setcc = 1'b1; dr = if_instr[11:9];
                imm_sel = ImmOff6;
            end
            OP_STR: begin
                use1 = 1'b1; use2 = 1'b1; imm_sel = ImmOff6;
            end
            OP_ST, OP_STI: begin
                use2 = 1'b1; imm_sel = ImmOff9;
            end
            OP_BR:  imm_sel = ImmOff9;
            OP_JSR: begin
                use1 = !if_instr[11]; ld_reg = 1'b1; dr = REG_R7; imm_sel = ImmOff11;
            end
            OP_JMP: use1 = 1'b1;
            OP_TRAP: begin
                ld_reg = 1'b1; dr = REG_R7; imm_sel = ImmTrap8;
            end
            OP_RTI, OP_RES: begin
`ifdef LC3_DECODE_ILLEGAL_EN
                illegal = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    // Assemble the ID/EX payload from decode and register-file data.
    always_comb begin
        dec        = '0;
        dec.op     = op;
        dec.dr     = dr;
        dec.ld_reg = ld_reg;
        dec.setcc  = setcc;
        dec.src1   = SR1out;
        dec.src2   = (((op == OP_ADD) || (op == OP_AND)) && if_instr[5])
                     ? {{11{if_instr[4]}}, if_instr[4:0]} : SR2out;
        dec.imm    = imm_extend(if_instr, imm_sel);
        dec.nzp    = (op == OP_BR) ? if_instr[11:9] : 3'd0;
        dec.pc     = if_pc;
    end

    lc3_scoreboard u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_i      (issue && ld_reg),
        .inc_idx_i  (dr),
        .wb_dec_i   (wb_valid),
        .wb_idx_i   (wb_dr),
        .fl_dec_i   (flush && ex_valid_q && idex_q.ld_reg),
        .fl_idx_i   (idex_q.dr),
        .src1_i     (SR1),
        .src2_i     (SR2),
        .dst_i      (dr),
        .busy1_o    (busy1),
        .busy2_o    (busy2),
        .dst_full_o (dst_full)
    );

    // Handshake: stall on RAW hazard, full destination counter or back-pressure.
    always_comb begin
        hazard   = (use1 && busy1) || (use2 && busy2) || (ld_reg && dst_full);
        if_ready = !flush && !hazard && (!ex_valid_q || ex_ready);
        issue    = if_valid && if_ready;
    end

    // ID/EX next state: flush beats issue, issue beats drain/hold.
    always_comb begin
        ex_valid_d = ex_valid_q;
        idex_d     = idex_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (issue) begin
            ex_valid_d = 1'b1;
            idex_d     = dec;
        end else if (ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            idex_q     <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            idex_q     <= idex_d;
        end
    end

`ifdef LC3_DECODE_ILLEGAL_EN
    logic illegal_d, illegal_q;

    // Illegal flag travels with the payload under the same load condition.
    always_comb begin
        illegal_d = illegal_q;
        if (!flush && issue) begin
            illegal_d = illegal;
        end
    end

    // Illegal flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign ex_illegal = illegal_q;
`else
    assign ex_illegal = 1'b0;
`endif

    assign ex_valid  = ex_valid_q;
    assign ex_op     = idex_q.op;
    assign ex_dr     = idex_q.dr;
    assign ex_ld_reg = idex_q.ld_reg;
    assign ex_setcc  = idex_q.setcc;
    assign ex_src1   = idex_q.src1;
    assign ex_src2   = idex_q.src2;
    assign ex_imm    = idex_q.imm;
    assign ex_nzp    = idex_q.nzp;
    assign ex_pc     = idex_q.pc;

endmodule

// File: tb/tb_lc3_decode_stage.sv
// Bench for lc3_decode_stage: spec-level model checked every negedge, plus
// directed vectors with literal expectations.
module tb_lc3_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid, if_ready;
    logic [15:0] if_instr, if_pc;
    logic [2:0]  SR1, SR2;
    logic [15:0] SR1out, SR2out;
    logic        wb_valid;
    logic [2:0]  wb_dr;
    logic        flush, ex_ready, ex_valid;
    logic [3:0]  ex_op;
    logic [2:0]  ex_dr;
    logic        ex_ld_reg, ex_setcc;
    logic [15:0] ex_src1, ex_src2, ex_imm;
    logic [2:0]  ex_nzp;
    logic [15:0] ex_pc;
    logic        ex_illegal;

    logic [15:0] rf [8];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] pc_ctr;

    always #5 clk = ~clk;

    assign SR1out = rf[SR1];
    assign SR2out = rf[SR2];

    lc3_decode_stage dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .SR1(SR1), .SR2(SR2),
        .SR1out(SR1out), .SR2out(SR2out), .wb_valid(wb_valid), .wb_dr(wb_dr),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_op(ex_op),
        .ex_dr(ex_dr), .ex_ld_reg(ex_ld_reg), .ex_setcc(ex_setcc),
        .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_imm(ex_imm), .ex_nzp(ex_nzp),
        .ex_pc(ex_pc), .ex_illegal(ex_illegal)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [3:0]  op;
        logic [2:0]  dr;
        logic        ld;
        logic        setcc;
        logic [15:0] src1;
        logic [15:0] src2;
        logic [15:0] imm;
        logic [2:0]  nzp;
        logic [15:0] pc;
        logic        ill;
        logic        u1;
        logic        u2;
        logic [2:0]  s1;
        logic [2:0]  s2;
    } dec_t;

    int   pend [8];
    logic m_valid;
    dec_t m;

    // Sign-extend the low n bits of a word using integer arithmetic.
    function automatic logic [15:0] sx(input logic [15:0] ins, input int n);
        int v;
        v = int'(ins) & ((1 << n) - 1);
        if (v >= (1 << (n - 1))) v = v - (1 << n);
        return 16'(v);
    endfunction

    function automatic dec_t model_dec(input logic [15:0] ins, input logic [15:0] pc);
        dec_t d;
        int   op;
        d = '0;
        op = int'(ins[15:12]);
        d.op = ins[15:12];
        d.pc = pc;
        d.s1 = ins[8:6];
        d.s2 = (op == 3 || op == 7 || op == 11) ? ins[11:9] : ins[2:0];
        case (op)
            1, 5: begin d.u1 = 1; d.u2 = !ins[5]; d.ld = 1; d.setcc = 1; d.dr = ins[11:9]; end
            9:    begin d.u1 = 1; d.ld = 1; d.setcc = 1; d.dr = ins[11:9]; end
            2, 10, 14: begin d.ld = 1; d.setcc = 1; d.dr = ins[11:9]; d.imm = sx(ins, 9); end
            6:    begin d.u1 = 1; d.ld = 1; d.setcc = 1; d.dr = ins[11:9]; d.imm = sx(ins, 6); end
            7:    begin d.u1 = 1; d.u2 = 1; d.imm = sx(ins, 6); end
            3, 11: begin d.u2 = 1; d.imm = sx(ins, 9); end
            0:    begin d.imm = sx(ins, 9); d.nzp = ins[11:9]; end
            4:    begin d.u1 = !ins[11]; d.ld = 1; d.dr = 3'd7; d.imm = sx(ins, 11); end
            12:   d.u1 = 1;
            15:   begin d.ld = 1; d.dr = 3'd7; d.imm = 16'(int'(ins) % 256); end
`ifdef LC3_DECODE_ILLEGAL_EN
            8, 13: d.ill = 1;
`endif
            default: ;
        endcase
        d.src1 = rf[d.s1];
        d.src2 = ((op == 1 || op == 5) && ins[5]) ? sx(ins, 5) : rf[d.s2];
        return d;
    endfunction

    function automatic bit src_blocked(input logic [2:0] s);
        return (pend[s] != 0) && !(pend[s] == 1 && wb_valid && wb_dr == s);
    endfunction

    function automatic bit model_ready(input dec_t d);
        bit hz;
        hz = (d.u1 && src_blocked(d.s1)) || (d.u2 && src_blocked(d.s2)) ||
             (d.ld && pend[d.dr] >= 3);
        return !flush && !hz && (!m_valid || ex_ready);
    endfunction

    // Model state update at each active edge.
    always @(posedge clk or negedge rst_n) begin
        dec_t d;
        bit   iss;
        if (!rst_n) begin
            m_valid = 0;
            m       = '0;
            for (int i = 0; i < 8; i++) pend[i] = 0;
        end else begin
            d   = model_dec(if_instr, if_pc);
            iss = if_valid && model_ready(d);
            if (iss && d.ld) pend[d.dr]++;
            if (wb_valid) pend[wb_dr]--;
            if (flush && m_valid && m.ld) pend[m.dr]--;
            if (flush) m_valid = 0;
            else if (iss) begin m = d; m_valid = 1; end
            else if (ex_ready) m_valid = 0;
        end
    end

    // Compare DUT against model away from the active edge.
    always @(negedge clk) begin
        dec_t d;
        if (rst_n) begin
            d = model_dec(if_instr, if_pc);
            chk("if_ready", 16'(if_ready), 16'(model_ready(d)));
            if (d.u1) chk("sr1_addr", 16'(SR1), 16'(d.s1));
            if (d.u2) chk("sr2_addr", 16'(SR2), 16'(d.s2));
            chk("ex_valid", 16'(ex_valid), 16'(m_valid));
            if (m_valid) begin
                chk("ex_op", 16'(ex_op), 16'(m.op));
                chk("ex_ld_reg", 16'(ex_ld_reg), 16'(m.ld));
                if (m.ld) chk("ex_dr", 16'(ex_dr), 16'(m.dr));
                chk("ex_setcc", 16'(ex_setcc), 16'(m.setcc));
                chk("ex_src1", ex_src1, m.src1);
                chk("ex_src2", ex_src2, m.src2);
                chk("ex_imm", ex_imm, m.imm);
                if (m.op == 4'd0) chk("ex_nzp", 16'(ex_nzp), 16'(m.nzp));
                chk("ex_pc", ex_pc, m.pc);
                chk("ex_illegal", 16'(ex_illegal), 16'(m.ill));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] ins);
        int n;
        if_valid = 1; if_instr = ins; if_pc = pc_ctr; pc_ctr = pc_ctr + 16'd1;
        #1;
        n = 0;
        while (!if_ready && n < 8) begin
            @(posedge clk); #2; n++;
        end
        chk("send_accept", 16'(if_ready), 16'd1);
        cyc();
        if_valid = 0;
    endtask

    task automatic wb(input logic [2:0] r, input logic [15:0] val);
        wb_valid = 1; wb_dr = r; rf[r] = val;
        cyc();
        wb_valid = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0; if_valid = 0; if_instr = 16'h0; if_pc = 16'h0;
        wb_valid = 0; wb_dr = 3'd0; flush = 0; ex_ready = 1; pc_ctr = 16'h3001;
        rf[0] = 16'h0000; rf[1] = 16'h0011; rf[2] = 16'h0005; rf[3] = 16'h0033;
        rf[4] = 16'h00F0; rf[5] = 16'h0055; rf[6] = 16'h0066; rf[7] = 16'h0077;
        #12;
        chk("rst_ex_valid", 16'(ex_valid), 16'd0);
        chk("rst_ex_op", 16'(ex_op), 16'd0);
        chk("rst_ex_src1", ex_src1, 16'd0);
        chk("rst_ex_imm", ex_imm, 16'd0);
        chk("rst_ex_pc", ex_pc, 16'd0);
        chk("rst_if_ready", 16'(if_ready), 16'd1);
        cyc();
        rst_n = 1;
        cyc();

        // ADD R1,R2,#-3
        send(16'h12BD);
        chk("add_valid", 16'(ex_valid), 16'd1);
        chk("add_src1", ex_src1, 16'h0005);
        chk("add_src2", ex_src2, 16'hFFFD);
        chk("add_dr", 16'(ex_dr), 16'd1);
        chk("add_setcc", 16'(ex_setcc), 16'd1);

        // AND R3,R1,R4 stalls on R1 until its writeback
        if_valid = 1; if_instr = 16'h5644; if_pc = pc_ctr; pc_ctr = pc_ctr + 16'd1;
        #1 chk("raw_stall0", 16'(if_ready), 16'd0);
        cyc();
        chk("raw_stall1", 16'(if_ready), 16'd0);
        cyc();
        wb_valid = 1; wb_dr = 3'd1; rf[1] = 16'h0777;
        #1 chk("raw_bypass_ready", 16'(if_ready), 16'd1);
        cyc();
        wb_valid = 0; if_valid = 0;
        chk("and_op", 16'(ex_op), 16'h5);
        chk("and_src1", ex_src1, 16'h0777);
        chk("and_src2", ex_src2, 16'h00F0);
        chk("and_dr", 16'(ex_dr), 16'd3);

        // Back-pressure: NOT R5,R6 held while LEA R0,#5 waits
        send(16'h9BBF);
        ex_ready = 0;
        if_valid = 1; if_instr = 16'hE005; if_pc = pc_ctr; pc_ctr = pc_ctr + 16'd1;
        #1 chk("bp_ready0", 16'(if_ready), 16'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_hold_op", 16'(ex_op), 16'h9);
            chk("bp_hold_src1", ex_src1, 16'h0066);
            chk("bp_ready", 16'(if_ready), 16'd0);
        end
        ex_ready = 1;
        #1 chk("bp_release", 16'(if_ready), 16'd1);
        cyc();
        if_valid = 0;
        chk("lea_op", 16'(ex_op), 16'hE);
        chk("lea_imm", ex_imm, 16'h0005);
        wb(3'd3, 16'h0A33);
        wb(3'd5, 16'h0A55);
        wb(3'd0, 16'h0A00);

        // LDR R1,R2,#-1 flushed, then ADD R2,R1,R1 needs no stall
        send(16'h62BF);
        chk("ldr_imm", ex_imm, 16'hFFFF);
        flush = 1; ex_ready = 0;
        if_valid = 1; if_instr = 16'h1441; if_pc = pc_ctr; pc_ctr = pc_ctr + 16'd1;
        #1 chk("flush_ready", 16'(if_ready), 16'd0);
        cyc();
        flush = 0;
        chk("flush_kill", 16'(ex_valid), 16'd0);
        #1 chk("post_flush_ready", 16'(if_ready), 16'd1);
        ex_ready = 1;
        cyc();
        if_valid = 0;
        chk("add2_dr", 16'(ex_dr), 16'd2);
        wb(3'd2, 16'h0A22);

        // Three writers of R5 in flight; the fourth stalls
        send(16'h1A21);
        send(16'h1A21);
        send(16'h1A21);
        if_valid = 1; if_instr = 16'h1A21; if_pc = pc_ctr; pc_ctr = pc_ctr + 16'd1;
        #1 chk("sat_stall0", 16'(if_ready), 16'd0);
        cyc();
        chk("sat_stall1", 16'(if_ready), 16'd0);
        wb_valid = 1; wb_dr = 3'd5; rf[5] = 16'h0B55;
        cyc();
        wb_valid = 0;
        #1 chk("sat_release", 16'(if_ready), 16'd1);
        cyc();
        if_valid = 0;
        chk("sat_issue_dr", 16'(ex_dr), 16'd5);
        chk("sat_issue_src1", ex_src1, 16'h0A00);
        wb(3'd5, 16'h0C55);
        wb(3'd5, 16'h0D55);
        wb(3'd5, 16'h0E55);

        // Immediate forms
        send(16'hF025);
        chk("trap_dr", 16'(ex_dr), 16'd7);
        chk("trap_imm", ex_imm, 16'h0025);
        chk("trap_setcc", 16'(ex_setcc), 16'd0);
        send(16'h0BFE);
        chk("br_nzp", 16'(ex_nzp), 16'd5);
        chk("br_imm", ex_imm, 16'hFFFE);
        send(16'h4C00);
        chk("jsr_imm", ex_imm, 16'hFC00);
        send(16'h7702);
        chk("str_src1", ex_src1, 16'h00F0);
        chk("str_src2", ex_src2, 16'h0A33);
        chk("str_imm", ex_imm, 16'h0002);
        send(16'hD000);
        chk("res_ld_reg", 16'(ex_ld_reg), 16'd0);
`ifdef LC3_DECODE_ILLEGAL_EN
        chk("res_illegal", 16'(ex_illegal), 16'd1);
`else
        chk("res_illegal", 16'(ex_illegal), 16'd0);
`endif

        // Reset during a RAW stall
        send(16'h1C21);
        if_valid = 1; if_instr = 16'h5386; if_pc = pc_ctr; pc_ctr = pc_ctr + 16'd1;
        #1 chk("rst_stall", 16'(if_ready), 16'd0);
        cyc();
        rst_n = 0;
        #1;
        chk("midrst_valid", 16'(ex_valid), 16'd0);
        chk("midrst_ready", 16'(if_ready), 16'd1);
        cyc();
        rst_n = 1;
        #1 chk("postrst_ready", 16'(if_ready), 16'd1);
        cyc();
        if_valid = 0;
        chk("postrst_op", 16'(ex_op), 16'h5);
        chk("postrst_valid", 16'(ex_valid), 16'd1);
        cyc();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
